// File: rtl/rtdf_rx_dispatcher.sv
// RX FIFO packet dispatcher: parses the length/header words and routes the payload
// by EtherType to the stream or control consumer; drops runts, unknown and disabled types.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_LENGTH  | wait for word0, latch byte length, runt check
// S_HEADER  | pop 6 MAC words + EtherType word, classify on the 7th
// S_DATA    | forward payload words to the selected consumer
// S_DISCARD | pop and drop CRC words, runts and unsupported packets
module rtdf_rx_dispatcher #(
  parameter logic [15:0] STREAM_ETHERTYPE = 16'h88B5,
  parameter logic [15:0] CTRL_ETHERTYPE   = 16'h88B6,
  parameter int          CRC_ENABLE       = 1,
  parameter int          LEN_WIDTH        = 11
) (
  input  logic        clk_rx,
  input  logic        reset,
  input  logic [15:0] rx_fifo_rd_data,
  input  logic        rx_fifo_empty,
  output logic        rx_fifo_rd_req,
  input  logic        stream_enable,
  output logic        strm_valid,
  output logic [15:0] strm_data,
  output logic        strm_last,
  input  logic        strm_ready,
  output logic        ctrl_valid,
  output logic [15:0] ctrl_data,
  output logic        ctrl_last,
  input  logic        ctrl_ready,
  output logic [7:0]  stream_pkt_count,
  output logic [7:0]  ctrl_pkt_count,
  output logic [7:0]  drop_pkt_count
);

  typedef enum logic [1:0] {S_LENGTH, S_HEADER, S_DATA, S_DISCARD} state_t;

  localparam logic [LEN_WIDTH-1:0] C_HDR   = LEN_WIDTH'(14 + 4 * CRC_ENABLE);
  localparam logic [LEN_WIDTH-1:0] C_RUNT  = LEN_WIDTH'(16 + 4 * CRC_ENABLE);
  localparam logic [LEN_WIDTH-1:0] C_SEVEN = LEN_WIDTH'(7);
  localparam logic [LEN_WIDTH-1:0] C_ONE   = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] C_ZERO  = '0;

  function automatic logic [LEN_WIDTH-1:0] f_half_up(input logic [LEN_WIDTH-1:0] v);
    return (v >> 1) + {{(LEN_WIDTH-1){1'b0}}, v[0]};
  endfunction

  state_t               r_state;
  state_t               w_state_nxt;
  logic [LEN_WIDTH-1:0] r_cnt;
  logic [LEN_WIDTH-1:0] w_cnt_nxt;
  logic [LEN_WIDTH-1:0] r_len;
  logic                 r_sel_strm;
  logic [7:0]           r_strm_pkts;
  logic [7:0]           r_ctrl_pkts;
  logic [7:0]           r_drop_pkts;

  logic [LEN_WIDTH-1:0] w_len_in;
  logic                 w_runt;
  logic [15:0]          w_etype;
  logic                 w_is_strm;
  logic                 w_is_ctrl;
  logic [LEN_WIDTH-1:0] w_p;
  logic [LEN_WIDTH-1:0] w_d;
  logic                 w_pop;
  logic                 w_cnt_last;
  logic                 w_classify;
  logic                 w_runt_pop;

  assign w_len_in   = rx_fifo_rd_data[LEN_WIDTH-1:0];
  assign w_runt     = (w_len_in < C_RUNT);
  assign w_etype    = {rx_fifo_rd_data[7:0], rx_fifo_rd_data[15:8]};
  assign w_is_strm  = (w_etype == STREAM_ETHERTYPE) && stream_enable;
  assign w_is_ctrl  = (w_etype == CTRL_ETHERTYPE);
  // r_len >= C_RUNT whenever these are used, so the subtraction cannot wrap
  assign w_p        = f_half_up(r_len - C_HDR);
  assign w_d        = f_half_up(r_len) - C_SEVEN - w_p;
  assign w_pop      = rx_fifo_rd_req;
  assign w_cnt_last = (r_cnt == C_ONE);
  assign w_classify = (r_state == S_HEADER) && w_pop && w_cnt_last;
  assign w_runt_pop = (r_state == S_LENGTH) && w_pop && w_runt;

  always_ff @(posedge clk_rx) begin
    if (reset) begin
      r_state <= S_LENGTH;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_LENGTH: begin
        if (w_pop) begin
          if (w_runt) begin
            w_state_nxt = S_DISCARD;
            w_cnt_nxt   = f_half_up(w_len_in);
          end else begin
            w_state_nxt = S_HEADER;
            w_cnt_nxt   = C_SEVEN;
          end
        end
      end
      S_HEADER: begin
        if (w_pop) begin
          w_cnt_nxt = r_cnt - C_ONE;
          if (w_cnt_last) begin
            if (w_is_strm || w_is_ctrl) begin
              w_state_nxt = S_DATA;
              w_cnt_nxt   = w_p;
            end else begin
              w_state_nxt = S_DISCARD;
              w_cnt_nxt   = w_p + w_d;
            end
          end
        end
      end
      S_DATA: begin
        if (w_pop) begin
          w_cnt_nxt = r_cnt - C_ONE;
          if (w_cnt_last) begin
            w_state_nxt = (w_d != C_ZERO) ? S_DISCARD : S_LENGTH;
            w_cnt_nxt   = w_d;
          end
        end
      end
      S_DISCARD: begin
        if (r_cnt == C_ZERO) begin
          w_state_nxt = S_LENGTH;
        end else if (w_pop) begin
          w_cnt_nxt = r_cnt - C_ONE;
          if (w_cnt_last) w_state_nxt = S_LENGTH;
        end
      end
      default: w_state_nxt = S_LENGTH;
    endcase
  end

  always_comb begin
    rx_fifo_rd_req = 1'b0;
    strm_valid     = 1'b0;
    strm_last      = 1'b0;
    ctrl_valid     = 1'b0;
    ctrl_last      = 1'b0;
    if (!reset) begin
      case (r_state)
        S_LENGTH, S_HEADER: rx_fifo_rd_req = !rx_fifo_empty;
        S_DATA: begin
          if (r_sel_strm) begin
            strm_valid     = !rx_fifo_empty;
            strm_last      = w_cnt_last;
            rx_fifo_rd_req = strm_valid && strm_ready;
          end else begin
            ctrl_valid     = !rx_fifo_empty;
            ctrl_last      = w_cnt_last;
            rx_fifo_rd_req = ctrl_valid && ctrl_ready;
          end
        end
        S_DISCARD: rx_fifo_rd_req = !rx_fifo_empty && (r_cnt != C_ZERO);
        default: rx_fifo_rd_req = 1'b0;
      endcase
    end
  end

  assign strm_data = rx_fifo_rd_data;
  assign ctrl_data = rx_fifo_rd_data;

  always_ff @(posedge clk_rx) begin
    if (reset) begin
      r_len       <= '0;
      r_sel_strm  <= 1'b0;
      r_strm_pkts <= '0;
      r_ctrl_pkts <= '0;
      r_drop_pkts <= '0;
    end else begin
      if ((r_state == S_LENGTH) && w_pop) r_len <= w_len_in;
      if (w_classify) begin
        r_sel_strm <= w_is_strm;
        if (w_is_strm)      r_strm_pkts <= r_strm_pkts + 8'd1;
        else if (w_is_ctrl) r_ctrl_pkts <= r_ctrl_pkts + 8'd1;
        else                r_drop_pkts <= r_drop_pkts + 8'd1;
      end else if (w_runt_pop) begin
        r_drop_pkts <= r_drop_pkts + 8'd1;
      end
    end
  end

  assign stream_pkt_count = r_strm_pkts;
  assign ctrl_pkt_count   = r_ctrl_pkts;
  assign drop_pkt_count   = r_drop_pkts;

endmodule

// File: tb/tb_rtdf_rx_dispatcher.sv
// Directed bench for rtdf_rx_dispatcher: a behavioural show-ahead FIFO feeds packets,
// monitors capture every accepted beat, and each task checks its own scenario.
module tb_rtdf_rx_dispatcher;

  logic        clk_rx = 1'b0;
  logic        reset;
  logic [15:0] rx_fifo_rd_data;
  logic        rx_fifo_empty;
  logic        rx_fifo_rd_req;
  logic        stream_enable;
  logic        strm_valid, strm_last, strm_ready;
  logic [15:0] strm_data;
  logic        ctrl_valid, ctrl_last, ctrl_ready;
  logic [15:0] ctrl_data;
  logic [7:0]  stream_pkt_count, ctrl_pkt_count, drop_pkt_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_rx = ~clk_rx;

  rtdf_rx_dispatcher dut (
    .clk_rx           (clk_rx),
    .reset            (reset),
    .rx_fifo_rd_data  (rx_fifo_rd_data),
    .rx_fifo_empty    (rx_fifo_empty),
    .rx_fifo_rd_req   (rx_fifo_rd_req),
    .stream_enable    (stream_enable),
    .strm_valid       (strm_valid),
    .strm_data        (strm_data),
    .strm_last        (strm_last),
    .strm_ready       (strm_ready),
    .ctrl_valid       (ctrl_valid),
    .ctrl_data        (ctrl_data),
    .ctrl_last        (ctrl_last),
    .ctrl_ready       (ctrl_ready),
    .stream_pkt_count (stream_pkt_count),
    .ctrl_pkt_count   (ctrl_pkt_count),
    .drop_pkt_count   (drop_pkt_count)
  );

  // show-ahead FIFO model; reset flushes it like the real upstream FIFO
  logic [15:0] fifo_mem [0:1023];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        force_empty = 1'b0;

  assign rx_fifo_empty   = (rd_ptr == wr_ptr) || force_empty;
  assign rx_fifo_rd_data = fifo_mem[rd_ptr[9:0]];

  always @(posedge clk_rx) begin
    if (reset) rd_ptr <= wr_ptr;
    else if (rx_fifo_rd_req && !rx_fifo_empty) rd_ptr <= rd_ptr + 1;
  end

  int          cyc = 0;
  int          n_pops = 0;
  int          n_bad_pop = 0;
  int          n_sv = 0;
  int          n_cv = 0;
  logic [16:0] strm_mem [0:255];
  int          strm_cyc [0:255];
  int          strm_n = 0;
  logic [16:0] ctrl_mem [0:255];
  int          ctrl_n = 0;

  always @(posedge clk_rx) begin
    cyc <= cyc + 1;
    if (rx_fifo_rd_req && rx_fifo_empty) n_bad_pop <= n_bad_pop + 1;
    if (rx_fifo_rd_req) n_pops <= n_pops + 1;
    if (strm_valid) n_sv <= n_sv + 1;
    if (ctrl_valid) n_cv <= n_cv + 1;
    if (strm_valid && strm_ready) begin
      strm_mem[strm_n[7:0]] <= {strm_last, strm_data};
      strm_cyc[strm_n[7:0]] <= cyc;
      strm_n <= strm_n + 1;
    end
    if (ctrl_valid && ctrl_ready) begin
      ctrl_mem[ctrl_n[7:0]] <= {ctrl_last, ctrl_data};
      ctrl_n <= ctrl_n + 1;
    end
  end

  task automatic push_word(input logic [15:0] w);
    fifo_mem[wr_ptr[9:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  // word0, 6 MAC words, byte-swapped EtherType, payload base+i, then CRC filler
  task automatic push_pkt(input int len, input logic [15:0] et, input int npay,
                          input int ncrc, input logic [15:0] base);
    push_word(16'(len));
    for (int i = 0; i < 6; i++) push_word(16'hA000 + 16'(i));
    push_word({et[7:0], et[15:8]});
    for (int i = 0; i < npay; i++) push_word(base + 16'(i));
    for (int i = 0; i < ncrc; i++) push_word(16'hCC00 + 16'(i));
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((rd_ptr != wr_ptr) && (n < 500)) begin
      @(negedge clk_rx);
      n++;
    end
    repeat (3) @(negedge clk_rx);
    n_cmp++;
    if (n >= 500) begin
      n_bad++;
      $display("FAIL %s drain timeout: rd_ptr=%0d required wr_ptr=%0d", name, rd_ptr, wr_ptr);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk_rx);
    @(negedge clk_rx);
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({rx_fifo_rd_req, strm_valid, ctrl_valid, strm_last, ctrl_last} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b required 00000",
               {rx_fifo_rd_req, strm_valid, ctrl_valid, strm_last, ctrl_last});
    end
    n_cmp++;
    if ({stream_pkt_count, ctrl_pkt_count, drop_pkt_count} !== 24'h0) begin
      n_bad++;
      $display("FAIL reset_counters: got %h/%h/%h required 00/00/00",
               stream_pkt_count, ctrl_pkt_count, drop_pkt_count);
    end
  endtask

  task automatic test_stream();
    int s0 = strm_n, p0 = n_pops, c0 = n_cv, v0 = n_sv;
    logic [16:0] exp;
    push_pkt(24, 16'h88B5, 3, 2, 16'h5001);
    wait_drain("stream");
    n_cmp++;
    if (strm_n - s0 != 3) begin
      n_bad++; $display("FAIL stream_beats: got %0d required 3", strm_n - s0);
    end
    for (int i = 0; i < 3; i++) begin
      exp = {(i == 2), 16'h5001 + 16'(i)};
      n_cmp++;
      if (strm_mem[s0 + i] !== exp) begin
        n_bad++; $display("FAIL stream_word%0d: got %h required %h", i, strm_mem[s0 + i], exp);
      end
    end
    n_cmp++;
    if (strm_cyc[s0 + 2] - strm_cyc[s0] != 2) begin
      n_bad++; $display("FAIL stream_b2b: got span %0d required 2", strm_cyc[s0 + 2] - strm_cyc[s0]);
    end
    n_cmp++;
    if ((n_pops - p0 != 13) || (n_sv - v0 != 3) || (n_cv != c0)) begin
      n_bad++;
      $display("FAIL stream_pops: got pops=%0d sv=%0d cv=%0d required 13/3/0",
               n_pops - p0, n_sv - v0, n_cv - c0);
    end
    n_cmp++;
    if (stream_pkt_count !== 8'd1) begin
      n_bad++; $display("FAIL stream_count: got %0d required 1", stream_pkt_count);
    end
  endtask

  task automatic test_ctrl();
    int c0 = ctrl_n, v0 = n_sv, p0 = n_pops;
    logic [16:0] exp;
    push_pkt(23, 16'h88B6, 3, 2, 16'h6001);
    wait_drain("ctrl");
    n_cmp++;
    if (ctrl_n - c0 != 3) begin
      n_bad++; $display("FAIL ctrl_beats: got %0d required 3", ctrl_n - c0);
    end
    for (int i = 0; i < 3; i++) begin
      exp = {(i == 2), 16'h6001 + 16'(i)};
      n_cmp++;
      if (ctrl_mem[c0 + i] !== exp) begin
        n_bad++; $display("FAIL ctrl_word%0d: got %h required %h", i, ctrl_mem[c0 + i], exp);
      end
    end
    n_cmp++;
    if ((n_sv != v0) || (n_pops - p0 != 13)) begin
      n_bad++; $display("FAIL ctrl_side: got sv=%0d pops=%0d required 0/13", n_sv - v0, n_pops - p0);
    end
    n_cmp++;
    if (ctrl_pkt_count !== 8'd1) begin
      n_bad++; $display("FAIL ctrl_count: got %0d required 1", ctrl_pkt_count);
    end
  endtask

  task automatic test_drop();
    int v0 = n_sv, c0 = n_cv, p0 = n_pops, s0;
    push_pkt(60, 16'h0800, 21, 2, 16'h0100);
    wait_drain("drop");
    n_cmp++;
    if ((n_sv != v0) || (n_cv != c0) || (n_pops - p0 != 31)) begin
      n_bad++;
      $display("FAIL drop_silent: got sv=%0d cv=%0d pops=%0d required 0/0/31",
               n_sv - v0, n_cv - c0, n_pops - p0);
    end
    n_cmp++;
    if (drop_pkt_count !== 8'd1) begin
      n_bad++; $display("FAIL drop_count: got %0d required 1", drop_pkt_count);
    end
    s0 = strm_n;
    push_pkt(20, 16'h88B5, 1, 2, 16'h5A5A);
    wait_drain("drop_next");
    n_cmp++;
    if ((strm_n - s0 != 1) || (strm_mem[s0] !== {1'b1, 16'h5A5A}) || (stream_pkt_count !== 8'd2)) begin
      n_bad++;
      $display("FAIL drop_next: got beats=%0d word=%h count=%0d required 1/15a5a/2",
               strm_n - s0, strm_mem[s0], stream_pkt_count);
    end
  endtask

  task automatic test_backpressure();
    int s0 = strm_n, n = 0;
    logic [16:0] exp;
    push_pkt(30, 16'h88B5, 6, 2, 16'h7001);
    while ((strm_n - s0 < 2) && (n < 100)) begin
      @(negedge clk_rx);
      n++;
    end
    n_cmp++;
    if (n >= 100) begin
      n_bad++; $display("FAIL bp_start timeout: got beats=%0d required 2", strm_n - s0);
    end
    strm_ready = 1'b0;
    repeat (5) begin
      #1;
      n_cmp++;
      if ((rx_fifo_rd_req !== 1'b0) || (strm_valid !== 1'b1) || (strm_data !== 16'h7003)) begin
        n_bad++;
        $display("FAIL bp_stall: got req=%b valid=%b data=%h required 0/1/7003",
                 rx_fifo_rd_req, strm_valid, strm_data);
      end
      @(negedge clk_rx);
    end
    strm_ready = 1'b1;
    wait_drain("bp");
    n_cmp++;
    if (strm_n - s0 != 6) begin
      n_bad++; $display("FAIL bp_beats: got %0d required 6", strm_n - s0);
    end
    for (int i = 0; i < 6; i++) begin
      exp = {(i == 5), 16'h7001 + 16'(i)};
      n_cmp++;
      if (strm_mem[s0 + i] !== exp) begin
        n_bad++; $display("FAIL bp_word%0d: got %h required %h", i, strm_mem[s0 + i], exp);
      end
    end
  endtask

  task automatic test_enable();
    int v0 = n_sv, n = 0;
    stream_enable = 1'b0;
    push_pkt(24, 16'h88B5, 3, 2, 16'h8001);
    while ((drop_pkt_count == 8'd1) && (n < 100)) begin
      @(negedge clk_rx);
      n++;
    end
    stream_enable = 1'b1;
    wait_drain("enable");
    n_cmp++;
    if ((n_sv != v0) || (drop_pkt_count !== 8'd2) || (stream_pkt_count !== 8'd3)) begin
      n_bad++;
      $display("FAIL enable_drop: got sv=%0d drop=%0d strm=%0d required 0/2/3",
               n_sv - v0, drop_pkt_count, stream_pkt_count);
    end
  endtask

  task automatic test_runt();
    int p0 = n_pops, v0 = n_sv, c0 = n_cv, k0;
    push_word(16'd10);
    for (int i = 0; i < 5; i++) push_word(16'hEE00 + 16'(i));
    wait_drain("runt");
    n_cmp++;
    if ((n_pops - p0 != 6) || (drop_pkt_count !== 8'd3) || (n_sv != v0) || (n_cv != c0)) begin
      n_bad++;
      $display("FAIL runt10: got pops=%0d drop=%0d sv=%0d cv=%0d required 6/3/0/0",
               n_pops - p0, drop_pkt_count, n_sv - v0, n_cv - c0);
    end
    k0 = ctrl_n;
    push_word(16'd0);
    push_pkt(20, 16'h88B6, 1, 2, 16'h9999);
    wait_drain("runt0");
    n_cmp++;
    if ((drop_pkt_count !== 8'd4) || (ctrl_pkt_count !== 8'd2) || (ctrl_n - k0 != 1) ||
        (ctrl_mem[k0] !== {1'b1, 16'h9999})) begin
      n_bad++;
      $display("FAIL runt0: got drop=%0d ctrl=%0d beats=%0d word=%h required 4/2/1/19999",
               drop_pkt_count, ctrl_pkt_count, ctrl_n - k0, ctrl_mem[k0]);
    end
  endtask

  task automatic test_empty_gap();
    int s0 = strm_n, n = 0;
    logic [16:0] exp;
    push_pkt(24, 16'h88B5, 3, 2, 16'hB001);
    while ((strm_n - s0 < 1) && (n < 100)) begin
      @(negedge clk_rx);
      n++;
    end
    force_empty = 1'b1;
    repeat (3) begin
      #1;
      n_cmp++;
      if ((strm_valid !== 1'b0) || (rx_fifo_rd_req !== 1'b0) || (strm_n - s0 != 1)) begin
        n_bad++;
        $display("FAIL gap_hold: got valid=%b req=%b beats=%0d required 0/0/1",
                 strm_valid, rx_fifo_rd_req, strm_n - s0);
      end
      @(negedge clk_rx);
    end
    force_empty = 1'b0;
    wait_drain("gap");
    for (int i = 0; i < 3; i++) begin
      exp = {(i == 2), 16'hB001 + 16'(i)};
      n_cmp++;
      if (strm_mem[s0 + i] !== exp) begin
        n_bad++; $display("FAIL gap_word%0d: got %h required %h", i, strm_mem[s0 + i], exp);
      end
    end
    n_cmp++;
    if ((strm_n - s0 != 3) || (stream_pkt_count !== 8'd4)) begin
      n_bad++;
      $display("FAIL gap_count: got beats=%0d strm=%0d required 3/4", strm_n - s0, stream_pkt_count);
    end
  endtask

  task automatic test_reset_mid();
    int s0 = strm_n, k0, n = 0;
    push_pkt(30, 16'h88B5, 6, 2, 16'hD001);
    while ((strm_n - s0 < 2) && (n < 100)) begin
      @(negedge clk_rx);
      n++;
    end
    reset = 1'b1;
    @(posedge clk_rx);
    #1;
    n_cmp++;
    if ({rx_fifo_rd_req, strm_valid, ctrl_valid, strm_last, ctrl_last} !== 5'b0) begin
      n_bad++;
      $display("FAIL rstmid_outputs: got %b required 00000",
               {rx_fifo_rd_req, strm_valid, ctrl_valid, strm_last, ctrl_last});
    end
    n_cmp++;
    if ({stream_pkt_count, ctrl_pkt_count, drop_pkt_count} !== 24'h0) begin
      n_bad++;
      $display("FAIL rstmid_counters: got %h/%h/%h required 00/00/00",
               stream_pkt_count, ctrl_pkt_count, drop_pkt_count);
    end
    @(negedge clk_rx);
    reset = 1'b0;
    k0 = ctrl_n;
    push_pkt(20, 16'h88B6, 1, 2, 16'hE123);
    wait_drain("rstmid_next");
    n_cmp++;
    if ((ctrl_n - k0 != 1) || (ctrl_mem[k0] !== {1'b1, 16'hE123}) || (ctrl_pkt_count !== 8'd1)) begin
      n_bad++;
      $display("FAIL rstmid_next: got beats=%0d word=%h ctrl=%0d required 1/1e123/1",
               ctrl_n - k0, ctrl_mem[k0], ctrl_pkt_count);
    end
    n_cmp++;
    if (n_bad_pop != 0) begin
      n_bad++; $display("FAIL pop_when_empty: got %0d required 0", n_bad_pop);
    end
  endtask

  initial begin
    reset         = 1'b1;
    strm_ready    = 1'b1;
    ctrl_ready    = 1'b1;
    stream_enable = 1'b1;
    test_reset();
    test_stream();
    test_ctrl();
    test_drop();
    test_backpressure();
    test_enable();
    test_runt();
    test_empty_gap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rtdf_rx_dispatcher.md
Name: rtdf_rx_dispatcher

Overview:
- Sits between the Ethernet RX FIFO and the real-time data feed consumers, in the clk_rx domain.
- Owns the RX FIFO read port, parses each packet header and routes the payload to one of two consumers: the GPS sample stream path or the control/command path. Routing is by EtherType.
- Discards unsupported, disabled and runt packets, the Ethernet header and the CRC words.
- Exposes per-class packet counters for debug.

Parameters:
- STREAM_ETHERTYPE, 16'h88B5, EtherType routed to the stream port.
- CTRL_ETHERTYPE, 16'h88B6, EtherType routed to the control port.
- CRC_ENABLE, 1, packet length word includes 4 trailing CRC bytes, which are discarded.
- LEN_WIDTH, 11, width of the byte-length field in the first FIFO word.

Ports:
- clk_rx  in  1  receive clock; all logic in this domain.
- reset  in  1  synchronous, active-high.
- rx_fifo_rd_data  in  16  show-ahead RX FIFO head word; valid whenever rx_fifo_empty=0.
- rx_fifo_empty  in  1  RX FIFO empty.
- rx_fifo_rd_req  out  1  pops the head word at this clock edge.
- stream_enable  in  1  when low, stream-type packets are dropped.
- strm_valid / strm_data / strm_last  out  1/16/1  stream payload word, last-word flag.
- strm_ready  in  1  stream consumer accepts the word.
- ctrl_valid / ctrl_data / ctrl_last  out  1/16/1  control payload word, last-word flag.
- ctrl_ready  in  1  control consumer accepts the word.
- stream_pkt_count, ctrl_pkt_count, drop_pkt_count  out  8 each  packet counters; wrap modulo 256.

Behaviour:
- Word consumption: a word is consumed on each clock edge where rx_fifo_rd_req=1; rx_fifo_rd_req is never 1 while rx_fifo_empty=1.
- FIFO word framing: word0[LEN_WIDTH-1:0] is L, the byte count.
  - L covers dst MAC (6), src MAC (6), EtherType (2), payload, and CRC (4 if CRC_ENABLE).
  - Words 1-6 carry the MACs; word 7 carries the EtherType; the remaining words are payload, then CRC.
  - Total words after word0 is ceil(L/2).
- EtherType compare uses the byte-swapped word {d[7:0],d[15:8]}.
- Per-packet quantities:
  - H = 14 + 4*CRC_ENABLE.
  - P = ceil((L-H)/2) payload words.
  - D = ceil(L/2) - 7 - P trailing discard words.
- State LENGTH:
  - Pop word0 when non-empty and latch L.
  - If L < H+2 (runt), load remaining count ceil(L/2) and go to DISCARD (runt flag set); otherwise go to HEADER with a word counter of 7.
- State HEADER:
  - Pop one word per non-empty cycle.
  - On the 7th word, classify the packet:
    - STREAM: EtherType = STREAM_ETHERTYPE and stream_enable=1.
    - CTRL: EtherType = CTRL_ETHERTYPE.
    - DROP: any other case.
  - STREAM/CTRL: load P and go to DATA.
  - DROP: load P+D and go to DISCARD.
  - Increment the matching counter in the same cycle as classification.
  - stream_enable is sampled only at classification; changing it mid-packet has no effect on that packet.
- State DATA:
  - Selected port: valid = !rx_fifo_empty; data = rx_fifo_rd_data (combinational, zero latency); last = (remaining==1).
  - rx_fifo_rd_req = valid && ready of the selected port; the other port's valid stays 0.
  - Remaining count decrements per pop.
  - When the last word pops: go to DISCARD with D if D>0, else to LENGTH.
- State DISCARD:
  - rx_fifo_rd_req = !rx_fifo_empty; no valid asserted; decrement per pop.
  - When the count reaches 0, go to LENGTH.
  - A runt increments drop_pkt_count on entry to DISCARD; runts are never classified.
  - A runt with L=0 (count 0) returns to LENGTH the next cycle without popping.
- Backpressure: ready low in DATA stalls the FIFO indefinitely; valid and data hold while the FIFO is non-empty.
- FIFO empty mid-packet: state and counts hold; valid drops to 0.
- Ready is not required before valid; ready while valid=0 has no effect.
- Reset values: state LENGTH; all counters 0; rx_fifo_rd_req, strm_valid, ctrl_valid, strm_last, ctrl_last all 0.
- Reset mid-packet aborts the packet with no partial flush. The RX FIFO is cleared by the same reset upstream.
- All arithmetic is LEN_WIDTH bits, unsigned. The runt check precedes subtraction, so P never underflows.

Test Plan:
- Stream packet, L=24, CRC on, both readys=1 → 3 stream words delivered back-to-back, strm_last on the 3rd; then 2 CRC words popped with no valid; stream_pkt_count=1.
- Control packet, L=23 (odd) → P=3 words on ctrl port, ctrl_last on the 3rd, D=2; ctrl_pkt_count=1; strm_valid never asserted.
- EtherType 16'h0800, L=60 → 23 words popped silently after the header, no valid on either port; drop_pkt_count=1; the next packet parses correctly.
- Stream packet with strm_ready=0 for 5 cycles mid-payload → rx_fifo_rd_req=0 and strm_data stable during the stall; no word lost or duplicated.
- stream_enable=0 at classification, stream EtherType → dropped, drop_pkt_count increments; stream_enable raised mid-packet does not redirect it.
- Runt L=10; FIFO empty inserted between words; reset asserted mid-payload → runt: 5 words discarded, drop_pkt_count=1; empty: state holds with valid low; reset: all outputs and counters 0, state LENGTH the cycle after reset.
